// File: rtl/mos_la_readout_seq.sv
// mos_la_readout_seq
//   Readout sequencer from the decoder result to the logic-analyzer bus.
//   When the decoder strobes a valid result, the block snapshots it and
//   streams it as WORD_W-bit words, least-significant word first, over a
//   valid/ready handshake. It also counts completed frames and results
//   dropped while busy, so the management core can read every result
//   without tearing.
//
// Ports
//   clk_i, rst_ni      system clock, asynchronous active-low reset
//   vdd, vss           power pins (only with USE_POWER_PINS)
//   enable_i           capture enable
//   clear_i            synchronous clear of overflow / drop / frame counters
//   result_valid_i     one-cycle strobe: decoder_result_i is valid
//   decoder_result_i   decoder result
//   word_o             current output word
//   word_idx_o         index of the current word (0..NWORDS-1)
//   word_valid_o       word_o is valid
//   word_ready_i       LA side accepts the word
//   frame_done_o       one-cycle pulse after the last word transfers
//   busy_o             a frame is in flight
//   overflow_o         sticky: at least one result was dropped
//   drop_cnt_o         number of dropped results, saturates at 255
//   frame_cnt_o        number of completed frames, wraps
//
// States
//   state | meaning
//   IDLE  | no frame in flight, waiting for an enabled result strobe
//   SEND  | presenting snapshot words on the LA handshake
module mos_la_readout_seq #(
    parameter int RESULT_W = 66,
    parameter int WORD_W   = 32,
    parameter int NWORDS   = 3,
    parameter int CNT_W    = 16
) (
`ifdef USE_POWER_PINS
    inout  wire                 vdd,
    inout  wire                 vss,
`endif
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic                result_valid_i,
    input  logic [RESULT_W-1:0] decoder_result_i,
    output logic [WORD_W-1:0]   word_o,
    output logic [1:0]          word_idx_o,
    output logic                word_valid_o,
    input  logic                word_ready_i,
    output logic                frame_done_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic [7:0]          drop_cnt_o,
    output logic [CNT_W-1:0]    frame_cnt_o
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     idx_q;
    logic [NWORDS-1:0][WORD_W-1:0]  snap_q;
    logic [NWORDS*WORD_W-1:0]       snap_d;
    logic                           frame_done_q;
    logic                           overflow_q;
    logic [7:0]                     drop_cnt_q;
    logic [CNT_W-1:0]               frame_cnt_q;

    logic sending, take, xfer, last_xfer, capture, drop;

    // A strobe that lands on the last-word transfer is captured directly,
    // so back-to-back frames have no idle bubble and are not drops.
    assign sending   = (state_q == SEND);
    assign take      = result_valid_i & enable_i;
    assign xfer      = sending & word_ready_i;
    assign last_xfer = xfer & (idx_q == 2'(NWORDS-1));
    assign capture   = take & (~sending | last_xfer);
    assign drop      = take & sending & ~last_xfer;

    // Zero-extend the result so bits above RESULT_W in the top word are 0.
    always_comb begin
        snap_d                 = '0;
        snap_d[RESULT_W-1:0]   = decoder_result_i;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture) state_d = SEND;
            SEND:    if (last_xfer && !capture) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_q       <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            frame_cnt_q  <= '0;
        end else begin
            if (capture) begin
                snap_q <= snap_d;
                idx_q  <= '0;
            end else if (xfer && !last_xfer) begin
                idx_q  <= idx_q + 2'd1;
            end

            frame_done_q <= last_xfer;

            // Clear takes priority over a coincident drop or completion.
            if (clear_i) begin
                overflow_q  <= 1'b0;
                drop_cnt_q  <= '0;
                frame_cnt_q <= '0;
            end else begin
                if (drop) begin
                    overflow_q <= 1'b1;
                    if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
                end
                if (last_xfer) frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        busy_o       = sending;
        word_valid_o = sending;
        word_o       = snap_q[idx_q];
        word_idx_o   = idx_q;
        frame_done_o = frame_done_q;
        overflow_o   = overflow_q;
        drop_cnt_o   = drop_cnt_q;
        frame_cnt_o  = frame_cnt_q;
    end

endmodule

// File: tb/tb_mos_la_readout_seq.sv
module tb_mos_la_readout_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        rvalid;
    logic [65:0] result;
    logic [31:0] word;
    logic [1:0]  word_idx;
    logic        word_valid;
    logic        ready;
    logic        frame_done;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [15:0] frame_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mos_la_readout_seq dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .enable_i         (enable),
        .clear_i          (clear),
        .result_valid_i   (rvalid),
        .decoder_result_i (result),
        .word_o           (word),
        .word_idx_o       (word_idx),
        .word_valid_o     (word_valid),
        .word_ready_i     (ready),
        .frame_done_o     (frame_done),
        .busy_o           (busy),
        .overflow_o       (overflow),
        .drop_cnt_o       (drop_cnt),
        .frame_cnt_o      (frame_cnt)
    );

    // Inputs change on the falling edge; outputs are checked on the falling edge.
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; rvalid = 1'b0;
        result = '0; ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({word, word_idx, word_valid, frame_done, busy, overflow, drop_cnt, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got word=%h idx=%0d v=%b fd=%b busy=%b ov=%b drop=%0d fc=%0d want all 0",
                     word, word_idx, word_valid, frame_done, busy, overflow, drop_cnt, frame_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        ready = 1'b1; result = 66'h2_DEADBEEF_12345678; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        tests++;
        if (word_valid !== 1'b1 || word !== 32'h12345678 || word_idx !== 2'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL basic_w0: got v=%b word=%h idx=%0d busy=%b want v=1 12345678 idx0 busy1", word_valid, word, word_idx, busy);
        end
        @(negedge clk);
        tests++;
        if (word_valid !== 1'b1 || word !== 32'hDEADBEEF || word_idx !== 2'd1) begin
            fails++; $display("FAIL basic_w1: got v=%b word=%h idx=%0d want v=1 DEADBEEF idx1", word_valid, word, word_idx);
        end
        @(negedge clk);
        tests++;
        if (word_valid !== 1'b1 || word !== 32'h00000002 || word_idx !== 2'd2 || frame_done !== 1'b0) begin
            fails++; $display("FAIL basic_w2: got v=%b word=%h idx=%0d fd=%b want v=1 00000002 idx2 fd0", word_valid, word, word_idx, frame_done);
        end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1 || busy !== 1'b0 || word_valid !== 1'b0) begin
            fails++; $display("FAIL basic_done: got fd=%b fc=%0d busy=%b v=%b want fd1 fc1 busy0 v0", frame_done, frame_cnt, busy, word_valid);
        end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL basic_fd_pulse: got fd=%b want 0", frame_done); end
    endtask

    task automatic test_backpressure();
        ready = 1'b0; result = 66'h1_CAFEF00D_0BADC0DE; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        tests++;
        if (word_valid !== 1'b1 || word !== 32'h0BADC0DE || word_idx !== 2'd0) begin
            fails++; $display("FAIL bp_w0: got v=%b word=%h idx=%0d want v=1 0BADC0DE idx0", word_valid, word, word_idx);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            result = {$urandom_range(3, 0), $urandom(), $urandom()};
            @(negedge clk);
            tests++;
            if (word_valid !== 1'b1 || word !== 32'hCAFEF00D || word_idx !== 2'd1) begin
                fails++; $display("FAIL bp_stall%0d: got v=%b word=%h idx=%0d want v=1 CAFEF00D idx1", i, word_valid, word, word_idx);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        tests++;
        if (word !== 32'h00000001 || word_idx !== 2'd2) begin
            fails++; $display("FAIL bp_w2: got word=%h idx=%0d want 00000001 idx2", word, word_idx);
        end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd2 || busy !== 1'b0) begin
            fails++; $display("FAIL bp_done: got fd=%b fc=%0d busy=%b want fd1 fc2 busy0", frame_done, frame_cnt, busy);
        end
    endtask

    task automatic test_drops();
        ready = 1'b0; result = 66'h3_11112222_33334444; rvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            result = {2'b00, 32'h0, 32'hF0F0_0000 + 32'(i)};
            @(negedge clk);
        end
        rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd3 || word !== 32'h33334444 || word_idx !== 2'd0) begin
            fails++; $display("FAIL drop_3: got ov=%b drop=%0d word=%h idx=%0d want ov1 drop3 33334444 idx0", overflow, drop_cnt, word, word_idx);
        end
        rvalid = 1'b1;
        repeat (300) @(negedge clk);
        rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
            fails++; $display("FAIL drop_sat: got drop=%0d ov=%b want 255 ov1", drop_cnt, overflow);
        end
        ready = 1'b1;
        @(negedge clk);
        tests++;
        if (word !== 32'h11112222) begin fails++; $display("FAIL drop_snap_w1: got %h want 11112222", word); end
        @(negedge clk);
        tests++;
        if (word !== 32'h00000003) begin fails++; $display("FAIL drop_snap_w2: got %h want 00000003", word); end
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd3) begin
            fails++; $display("FAIL drop_done: got fd=%b fc=%0d want fd1 fc3", frame_done, frame_cnt);
        end
    endtask

    task automatic test_enable_clear();
        ready = 1'b0; result = 66'h0_00000000_55555555; rvalid = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; rvalid = 1'b0;
        tests++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || frame_cnt !== 16'd0 || busy !== 1'b1) begin
            fails++; $display("FAIL clear_drop: got ov=%b drop=%0d fc=%0d busy=%b want ov0 drop0 fc0 busy1", overflow, drop_cnt, frame_cnt, busy);
        end
        ready = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
            fails++; $display("FAIL clear_frame_done: got fd=%b fc=%0d want fd1 fc1", frame_done, frame_cnt);
        end
        enable = 1'b0; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || word_valid !== 1'b0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL enable_low: got busy=%b v=%b drop=%0d ov=%b want 0 0 0 0", busy, word_valid, drop_cnt, overflow);
        end
        enable = 1'b1;
    endtask

    task automatic test_back_to_back();
        ready = 1'b1; result = 66'h0_AAAA0001_AAAA0000; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (word_idx !== 2'd2 || word !== 32'h00000000) begin
            fails++; $display("FAIL b2b_a_w2: got idx=%0d word=%h want idx2 00000000", word_idx, word);
        end
        result = 66'h1_BBBB0001_BBBB0000; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        tests++;
        if (frame_done !== 1'b1 || busy !== 1'b1 || word_idx !== 2'd0 || word !== 32'hBBBB0000) begin
            fails++; $display("FAIL b2b_no_bubble: got fd=%b busy=%b idx=%0d word=%h want fd1 busy1 idx0 BBBB0000", frame_done, busy, word_idx, word);
        end
        @(negedge clk);
        tests++;
        if (word !== 32'hBBBB0001 || frame_done !== 1'b0) begin
            fails++; $display("FAIL b2b_b_w1: got word=%h fd=%b want BBBB0001 fd0", word, frame_done);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd3 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            fails++; $display("FAIL b2b_counts: got fd=%b fc=%0d drop=%0d ov=%b want fd1 fc3 drop0 ov0", frame_done, frame_cnt, drop_cnt, overflow);
        end
    endtask

    task automatic test_reset_mid_frame();
        ready = 1'b0; result = 66'h2_77777777_66666666; rvalid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rvalid = 1'b0;
        tests++;
        if (busy !== 1'b1 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            fails++; $display("FAIL rmf_pre: got busy=%b ov=%b drop=%0d want 1 1 1", busy, overflow, drop_cnt);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({word, word_idx, word_valid, frame_done, busy, overflow, drop_cnt, frame_cnt} !== '0) begin
            fails++;
            $display("FAIL rmf_async: got word=%h idx=%0d v=%b fd=%b busy=%b ov=%b drop=%0d fc=%0d want all 0",
                     word, word_idx, word_valid, frame_done, busy, overflow, drop_cnt, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++; $display("FAIL rmf_idle: got busy=%b fd=%b want 0 0", busy, frame_done);
        end
        ready = 1'b1; result = 66'h0_00000000_0000ABCD; rvalid = 1'b1;
        @(negedge clk);
        rvalid = 1'b0;
        tests++;
        if (word_valid !== 1'b1 || word_idx !== 2'd0 || word !== 32'h0000ABCD) begin
            fails++; $display("FAIL rmf_restart: got v=%b idx=%0d word=%h want v1 idx0 0000ABCD", word_valid, word_idx, word);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (frame_cnt !== 16'd1) begin fails++; $display("FAIL rmf_count: got fc=%0d want 1", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_drops();
        test_enable_clear();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mos_la_readout_seq.md
Name: mos_la_readout_seq

Overview:
- Sequencer for the decoder-result readout path toward the logic-analyzer (LA) bus.
- Snapshots the wide decoder result when the decoder flags it valid, then streams it as WORD_W-bit words, least-significant word first, over a valid/ready handshake.
- Tracks completed frames and results dropped while busy, so the management core can read out every result coherently without tearing.

Parameters:
- RESULT_W, 66, width of decoder result.
- WORD_W, 32, width of each output word.
- NWORDS, 3, words per frame; must equal ceil(RESULT_W/WORD_W).
- CNT_W, 16, width of frame counter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- vdd/vss  inout  1  power pins, present only under USE_POWER_PINS
- enable_i  in  1  capture enable
- clear_i  in  1  synchronous clear of status and counters
- result_valid_i  in  1  single-cycle strobe: decoder_result_i is valid
- decoder_result_i  in  RESULT_W  decoder result
- word_o  out  WORD_W  current output word
- word_idx_o  out  2  index of current word (0..NWORDS-1)
- word_valid_o  out  1  word_o is valid
- word_ready_i  in  1  LA side accepts word
- frame_done_o  out  1  one-cycle pulse when the last word transfers
- busy_o  out  1  a frame is in flight
- overflow_o  out  1  sticky: at least one result dropped
- drop_cnt_o  out  8  results dropped; saturates at 255
- frame_cnt_o  out  CNT_W  completed frames; wraps

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; snapshot register = 0; every output = 0.
- Clock and reset: clk_i and rst_ni are the only clock and reset; reset is asynchronous and active-low.
- States:
  - IDLE -> SEND when result_valid_i & enable_i. The snapshot captures decoder_result_i on that edge; word_idx = 0.
  - SEND: word_valid_o = 1; word_o = snapshot[idx*WORD_W +: WORD_W]. For the top word, bits above RESULT_W are zero (default: word 2 = {30'b0, result[65:64]}).
  - Transfer occurs on a cycle with word_valid_o & word_ready_i.
    - Transfer with idx < NWORDS-1: idx increments.
    - Transfer with idx = NWORDS-1: frame_done_o pulses next cycle; frame_cnt_o increments (wraps); state returns to IDLE.
- Latency:
  - Strobe in cycle N -> word_valid_o high in cycle N+1.
  - With ready held high, one word per cycle: 3 cycles per frame, back-to-back frames possible.
- Outputs are registered and hold stable while word_valid_o & !word_ready_i; the snapshot never changes mid-frame.
- busy_o = (state == SEND).
- Simultaneous events:
  - Strobe (with enable_i) in the same cycle as the last-word transfer: the new result is captured. Next state is SEND with idx = 0, no IDLE bubble, and it is not counted as a drop.
  - Strobe during SEND otherwise: result discarded; overflow_o set; drop_cnt_o increments, saturating at 255.
  - Strobe with enable_i low: ignored entirely, not counted as a drop.
  - enable_i falling mid-frame: the frame completes normally.
- clear_i (synchronous):
  - Zeroes overflow_o, drop_cnt_o and frame_cnt_o next cycle; does not abort an in-flight frame.
  - If clear_i coincides with a drop or a frame completion, clear wins: counters read 0.
- word_ready_i while word_valid_o is low: no effect.
- Reset mid-frame: frame abandoned immediately; no frame_done_o pulse.

Test Plan:
- Reset, then strobe with result = 66'h2_DEADBEEF_12345678, ready held high -> words 32'h12345678, 32'hDEADBEEF, 32'h00000002 on consecutive cycles, idx 0,1,2; frame_done_o pulses once; frame_cnt_o = 1.
- Backpressure: ready low for 5 cycles on word 1 -> word_o stays 32'hDEADBEEF with valid high; a decoder_result_i change during the stall does not alter the output; the frame completes after ready rises.
- Drops: ready held low, 3 extra strobes during SEND -> overflow_o = 1, drop_cnt_o = 3; snapshot unchanged. Then 300 strobes while busy -> drop_cnt_o = 255.
- Back-to-back: strobe aligned with the last-word transfer -> next frame starts with no idle cycle; drop_cnt_o unchanged; frame_cnt_o increments twice.
- enable_i low plus strobe -> no frame and no drop. clear_i asserted together with a drop -> overflow_o = 0, drop_cnt_o = 0.
- rst_ni asserted asynchronously mid-frame (between clock edges) -> all outputs 0 immediately; after release the block is IDLE and the next strobe starts at idx 0.
